// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle signed multiply / divide responder.
// Ports: clock, reset (async, active-high); md_start/md_op/a_in/b_in
// request; hi_out/lo_out results; md_busy, md_done and div_zero status.
// Optional: define MD_FAST_ZERO_EN to short-cut zero-valued operations.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             md_start,
  input  logic             md_op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             md_busy,
  output logic             md_done,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int W = WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           op_q, op_d;
  logic           sa_q, sa_d;
  logic           sb_q, sb_d;
  logic [W-1:0]   mb_q, mb_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           done_q, done_d;
  logic           dz_q, dz_d;

  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W:0]     msum;
  logic [W:0]     dshift;
  logic           dge;
  logic [W-1:0]   ddiff;
  logic [2*W-1:0] pmag;
  logic [2*W-1:0] pres;
  logic [W-1:0]   qres;
  logic [W-1:0]   rres;

  assign a_mag = a_in[W-1] ? -a_in : a_in;
  assign b_mag = b_in[W-1] ? -b_in : b_in;

  // Multiply step: acc_q holds the unused multiplier bits, rem_q the
  // running upper half; add then shift the pair right by one.
  assign msum = {1'b0, rem_q}
              + (acc_q[0] ? {1'b0, mb_q} : {(W+1){1'b0}});

  // Restoring divide step: shift the next dividend bit into rem_q.
  assign dshift = {rem_q, acc_q[W-1]};
  assign dge    = dshift >= {1'b0, mb_q};
  assign ddiff  = dshift[W-1:0] - mb_q;

  // Quotient sign is the XOR of signs; remainder follows the dividend.
  assign pmag = {rem_q, acc_q};
  assign pres = (sa_q ^ sb_q) ? -pmag : pmag;
  assign qres = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign rres = sa_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    mb_d    = mb_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (md_start) begin
          if (md_op && (b_in == '0)) begin
            dz_d = 1'b1;
`ifdef MD_FAST_ZERO_EN
          end else if ((!md_op && ((a_in == '0) || (b_in == '0)))
                       || (md_op && (a_in == '0))) begin
            // Zero result: clear the datapath so FINISH yields 0/0.
            op_d    = md_op;
            sa_d    = 1'b0;
            sb_d    = 1'b0;
            mb_d    = '0;
            rem_d   = '0;
            acc_d   = '0;
            state_d = FINISH;
`endif
          end else begin
            op_d    = md_op;
            sa_d    = a_in[W-1];
            sb_d    = b_in[W-1];
            mb_d    = b_mag;
            rem_d   = '0;
            acc_d   = a_mag;
            cnt_d   = CW'(W - 1);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (op_q) begin
          rem_d = dge ? ddiff : dshift[W-1:0];
          acc_d = {acc_q[W-2:0], dge};
        end else begin
          rem_d = msum[W:1];
          acc_d = {msum[0], acc_q[W-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        if (op_q) begin
          hi_d = rres;
          lo_d = qres;
        end else begin
          hi_d = pres[2*W-1:W];
          lo_d = pres[W-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      mb_q    <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      mb_q    <= mb_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign md_busy  = (state_q != IDLE);
  assign md_done  = done_q;
  assign div_zero = dz_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multi-cycle signed multiply/divide responder for the multicycle CPU datapath; the control unit is the initiator.
- Control unit issues a start pulse with operands (from MDSrcA/MDSrcB) and an op select.
- Unit iterates, writes the HI/LO result registers and returns a done pulse.
- Flags divide-by-zero so the control unit can trap to the Div0 exception vector (0x000000FF).

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits, iteration count = WIDTH.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
md_start  input  1  request strobe, sampled only in IDLE
md_op  input  1  0 = signed multiply, 1 = signed divide
a_in  input  WIDTH  multiplicand / dividend
b_in  input  WIDTH  multiplier / divisor
hi_out  output  WIDTH  HI register: product upper half / remainder
lo_out  output  WIDTH  LO register: product lower half / quotient
md_busy  output  1  high while an operation is in flight
md_done  output  1  one-cycle pulse, HI/LO updated this cycle
div_zero  output  1  one-cycle pulse, divide by zero rejected

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset values:
  - hi_out = 0, lo_out = 0, md_busy = 0, md_done = 0, div_zero = 0.
  - State = IDLE; internal accumulators and counter cleared.
- States: IDLE, RUN, FINISH.
- IDLE:
  - md_start=1 at edge k latches a_in, b_in and md_op; converts both operands to magnitudes and records their signs; loads counter = WIDTH-1; goes to RUN.
  - Exception: md_op=1 and b_in=0 → stay in IDLE, pulse div_zero for the cycle after edge k, leave HI/LO unchanged.
- RUN:
  - One iteration per clock: shift-add for multiply, restoring shift-subtract for divide.
  - Counter decrements each cycle; at count 0 goes to FINISH.
  - RUN occupies edges k+1 .. k+WIDTH.
- FINISH (edge k+WIDTH+1):
  - Applies sign correction and writes HI/LO.
  - md_done=1 for exactly one cycle; returns to IDLE.
- md_busy = 1 in RUN and FINISH; 0 in IDLE.
- Latency: result visible and md_done high in the cycle after edge k+WIDTH+1, i.e. WIDTH+2 cycles after start is sampled.
- md_start while md_busy=1 is ignored; no queueing. Operand changes after edge k have no effect.
- Multiply: {hi,lo} = signed 2·WIDTH-bit product of a·b.
- Divide:
  - lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
  - Invariant: a = lo·b + hi.
- Overflow case: most-negative / -1 → lo = most-negative (wraps), hi = 0; no flag raised.
- HI/LO hold their value between operations; they change only in FINISH.
- md_done and div_zero are never high simultaneously.
- Reset during RUN or FINISH: immediate return to IDLE with reset values, no done pulse. The first md_start after reset deasserts is accepted normally.
- md_start in the same cycle as the FINISH→IDLE transition is not sampled; it must be held or re-issued in IDLE.

Optional Feature:
MD_FAST_ZERO_EN
- Defined: at the start edge, if any of the following holds, the unit skips RUN and goes straight to FINISH, producing HI = 0, LO = 0 with md_done in the cycle after edge k+1:
  - multiply with a_in = 0 or b_in = 0;
  - divide with a_in = 0 and b_in ≠ 0.
- Divide by zero is still checked first.
- Undefined: every accepted operation takes the full WIDTH-iteration path; latency is always WIDTH+2.

Test Plan:
1. Mult 7 × -3 (0x00000007, 0xFFFFFFFD) → hi=0xFFFFFFFF, lo=0xFFFFFFEB; md_done exactly 34 cycles after start sampled; md_busy high for 33 cycles.
2. Div -7 / 2 (0xFFFFFFF9, 0x00000002) → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0x00000000.
3. Div 100 / 0 → div_zero pulse 1 cycle after start; md_busy stays 0; md_done never asserted; HI/LO keep the prior values from scenario 2.
4. Mult 0x7FFFFFFF × 0x7FFFFFFF → hi=0x3FFFFFFF, lo=0x00000001. Re-pulse md_start with new operands at cycles 5 and 20 of the run → ignored, result unchanged, single md_done.
5. Start a divide, assert reset at RUN cycle 10 → all outputs 0 immediately (asynchronous), no md_done. After release, mult 3 × 4 → hi=0, lo=0x0000000C.
6. With MD_FAST_ZERO_EN: mult 0 × 0x12345678 → md_done 2 cycles after start, hi=lo=0. Without the macro the same stimulus gives md_done at 34 cycles with the same result.
